// File: rtl/data_mem_hs.sv
// Handshaked RV32 data memory: valid/ready request and response channels,
// configurable wait states, byte-lane stores, extended loads, error response.
module data_mem_hs #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int         WORDS     = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0] LAST_WAIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_next;
  logic [3:0]            cnt, cnt_next;
  logic                  accept, enter_resp;

  logic                  q_we;
  logic [2:0]            q_op;
  logic [ADDR_WIDTH-1:0] q_addr;
  logic [31:0]           q_wdata;

  logic                  a_we;
  logic [2:0]            a_op;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [31:0]           a_wdata;
  logic [1:0]            a_size;

  logic [31:0]           mem [WORDS];
  logic [31:0]           rd_word, ld_data, wr_data;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [3:0]            wr_be;
  logic                  misalign, bad_op, err, mem_we;

  assign req_ready = (state == IDLE) && rst_n;
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: if (accept) begin
        cnt_next   = 4'd0;
        state_next = (WAIT_STATES > 0) ? WAIT : RESP;
      end
      WAIT: if (cnt == LAST_WAIT) state_next = RESP;
            else                  cnt_next   = cnt + 4'd1;
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_resp = (state != RESP) && (state_next == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_we    <= 1'b0;
      q_op    <= 3'd0;
      q_addr  <= '0;
      q_wdata <= 32'd0;
    end else if (accept) begin
      q_we    <= req_we;
      q_op    <= req_op;
      q_addr  <= req_addr;
      q_wdata <= req_wdata;
    end
  end

  // With no wait states the access edge is the accept edge, so IDLE reads the ports directly.
  always_comb begin
    if (state == IDLE) begin
      a_we = req_we;  a_op = req_op;  a_addr = req_addr;  a_wdata = req_wdata;
    end else begin
      a_we = q_we;    a_op = q_op;    a_addr = q_addr;    a_wdata = q_wdata;
    end
  end

  assign a_size   = a_op[1:0];
  assign misalign = ((a_size == 2'b01) && a_addr[0]) ||
                    ((a_size == 2'b10) && (a_addr[1:0] != 2'b00));
  assign bad_op   = a_we ? (a_op >= 3'b011)
                         : ((a_op == 3'b011) || (a_op[2:1] == 2'b11));
  assign err      = misalign || bad_op;
  assign mem_we   = enter_resp && a_we && !err;

  assign rd_word = mem[a_addr[ADDR_WIDTH-1:2]];
  assign rd_half = a_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rd_byte = rd_word[7:0];
    case (a_addr[1:0])
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      2'd3:    rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  always_comb begin
    ld_data = 32'd0;
    case (a_op)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'd0, rd_byte};
      3'b101:  ld_data = {16'd0, rd_half};
      default: ld_data = 32'd0;
    endcase
  end

  always_comb begin
    wr_be   = 4'b1111;
    wr_data = a_wdata;
    case (a_size)
      2'b00: begin
        wr_be   = 4'b0001 << a_addr[1:0];
        wr_data = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = a_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{a_wdata[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = a_wdata;
      end
    endcase
  end

  // NOTE: the storage array has no reset; contents stay undefined until written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[a_addr[ADDR_WIDTH-1:2]][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_err   <= err;
      rsp_rdata <= (a_we || err) ? 32'd0 : ld_data;
    end
  end

endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench for data_mem_hs: one instance with no wait states, one with three,
// sharing the request bus and rsp_ready; only one instance is active at a time.
module tb_data_mem_hs;

  localparam logic [2:0] OP_B = 3'b000, OP_H = 3'b001, OP_W = 3'b010,
                         OP_BU = 3'b100, OP_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid0 = 1'b0, req_valid3 = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [11:0] req_addr = 12'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_ready = 1'b0;

  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;
  logic        req_ready3, rsp_valid3, rsp_err3;
  logic [31:0] rsp_rdata3;

  logic        slow = 1'b0;
  logic        sel_ready, sel_valid, sel_err;
  logic [31:0] sel_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign sel_ready = slow ? req_ready3 : req_ready0;
  assign sel_valid = slow ? rsp_valid3 : rsp_valid0;
  assign sel_err   = slow ? rsp_err3   : rsp_err0;
  assign sel_rdata = slow ? rsp_rdata3 : rsp_rdata0;

  data_mem_hs #(.ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  data_mem_hs #(.ADDR_WIDTH(12), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction; request fields are scrambled right after acceptance.
  task automatic txn(input logic s, input logic we, input logic [2:0] op,
                     input logic [11:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int lat);
    slow = s;
    @(negedge clk);
    req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    if (s) req_valid3 = 1'b1; else req_valid0 = 1'b1;
    @(negedge clk);
    req_valid0 = 1'b0; req_valid3 = 1'b0;
    req_we = 1'($urandom); req_op = 3'($urandom); req_addr = 12'($urandom);
    req_wdata = $urandom;
    lat = 1;
    while (!sel_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata = sel_rdata;
    err   = sel_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic step(input string tag, input logic s, input logic we, input logic [2:0] op,
                      input logic [11:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    logic [31:0] rdata;
    logic        err;
    int          lat;
    txn(s, we, op, addr, wdata, rdata, err, lat);
    check({tag, ".lat"},   32'(lat), 32'(exp_lat));
    check({tag, ".rdata"}, rdata,    exp_rdata);
    check({tag, ".err"},   32'(err), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst.ready0", 32'(req_ready0), 32'd0);
    check("rst.valid0", 32'(rsp_valid0), 32'd0);
    check("rst.rdata0", rsp_rdata0,      32'd0);
    check("rst.err0",   32'(rsp_err0),   32'd0);
    check("rst.ready3", 32'(req_ready3), 32'd0);
    check("rst.valid3", 32'(rsp_valid3), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel.ready0", 32'(req_ready0), 32'd1);

    // Reset mid-WAIT drops a pending store.
    step("pre_sw", 1'b1, 1'b1, OP_W, 12'h050, 32'h1111_1111, 32'd0, 1'b0, 4);
    slow = 1'b1;
    @(negedge clk);
    req_we = 1'b1; req_op = OP_W; req_addr = 12'h050; req_wdata = 32'hCAFE_F00D;
    req_valid3 = 1'b1;
    @(negedge clk);
    req_valid3 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.valid3", 32'(rsp_valid3), 32'd0);
    check("midrst.ready3", 32'(req_ready3), 32'd0);
    repeat (2) @(negedge clk);
    check("midrst.valid3_held", 32'(rsp_valid3), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst.ready3_rel", 32'(req_ready3), 32'd1);
    step("midrst_lw", 1'b1, 1'b0, OP_W, 12'h050, 32'd0, 32'h1111_1111, 1'b0, 4);

    // Word write/read, no wait states.
    step("sw010", 1'b0, 1'b1, OP_W, 12'h010, 32'hDEAD_BEEF, 32'd0, 1'b0, 1);
    step("lw010", 1'b0, 1'b0, OP_W, 12'h010, 32'd0, 32'hDEAD_BEEF, 1'b0, 1);

    // Byte/half extension.
    step("sw020",  1'b0, 1'b1, OP_W,  12'h020, 32'h80FF_7F01, 32'd0, 1'b0, 1);
    step("lb023",  1'b0, 1'b0, OP_B,  12'h023, 32'd0, 32'hFFFF_FF80, 1'b0, 1);
    step("lbu023", 1'b0, 1'b0, OP_BU, 12'h023, 32'd0, 32'h0000_0080, 1'b0, 1);
    step("lh022",  1'b0, 1'b0, OP_H,  12'h022, 32'd0, 32'hFFFF_80FF, 1'b0, 1);
    step("lhu020", 1'b0, 1'b0, OP_HU, 12'h020, 32'd0, 32'h0000_7F01, 1'b0, 1);
    step("lb021",  1'b0, 1'b0, OP_B,  12'h021, 32'd0, 32'h0000_007F, 1'b0, 1);

    // Partial stores; upper wdata bits must be ignored.
    step("sw030", 1'b0, 1'b1, OP_W, 12'h030, 32'h0000_0000, 32'd0, 1'b0, 1);
    step("sb031", 1'b0, 1'b1, OP_B, 12'h031, 32'hFFFF_FFAB, 32'd0, 1'b0, 1);
    step("sh032", 1'b0, 1'b1, OP_H, 12'h032, 32'hFFFF_1234, 32'd0, 1'b0, 1);
    step("lw030", 1'b0, 1'b0, OP_W, 12'h030, 32'd0, 32'h1234_AB00, 1'b0, 1);

    // Misalignment and illegal ops leave memory untouched.
    step("sw040",   1'b0, 1'b1, OP_W,   12'h040, 32'h5A5A_5A5A, 32'd0, 1'b0, 1);
    step("lw041",   1'b0, 1'b0, OP_W,   12'h041, 32'd0, 32'd0, 1'b1, 1);
    step("sh043",   1'b0, 1'b1, OP_H,   12'h043, 32'hFFFF_FFFF, 32'd0, 1'b1, 1);
    step("ld011",   1'b0, 1'b0, 3'b011, 12'h040, 32'd0, 32'd0, 1'b1, 1);
    step("st011",   1'b0, 1'b1, 3'b011, 12'h040, 32'h0, 32'd0, 1'b1, 1);
    step("sw042",   1'b0, 1'b1, OP_W,   12'h042, 32'h0, 32'd0, 1'b1, 1);
    step("lh041",   1'b0, 1'b0, OP_H,   12'h041, 32'd0, 32'd0, 1'b1, 1);
    step("lw040",   1'b0, 1'b0, OP_W,   12'h040, 32'd0, 32'h5A5A_5A5A, 1'b0, 1);

    // Wait states and backpressure, with a request held on the bus during RESP.
    step("sw050", 1'b1, 1'b1, OP_W, 12'h050, 32'h1357_9BDF, 32'd0, 1'b0, 4);
    slow = 1'b1;
    @(negedge clk);
    req_we = 1'b0; req_op = OP_W; req_addr = 12'h050; req_wdata = 32'd0;
    req_valid3 = 1'b1;
    @(negedge clk);
    req_valid3 = 1'b0;
    lat = 1;
    while (!rsp_valid3 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp.lat", 32'(lat), 32'd4);
    req_we = 1'b1; req_op = OP_W; req_addr = 12'h050; req_wdata = 32'hFFFF_FFFF;
    req_valid3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.valid", 32'(rsp_valid3), 32'd1);
      check("bp.rdata", rsp_rdata3,      32'h1357_9BDF);
      check("bp.ready", 32'(req_ready3), 32'd0);
    end
    rsp_ready = 1'b1;
    check("bp.ready_hs", 32'(req_ready3), 32'd0);
    @(negedge clk);
    check("bp.valid_after", 32'(rsp_valid3), 32'd0);
    check("bp.ready_after", 32'(req_ready3), 32'd1);
    req_valid3 = 1'b0;
    rsp_ready = 1'b0;
    step("bp_lw", 1'b1, 1'b0, OP_W, 12'h050, 32'd0, 32'h1357_9BDF, 1'b0, 4);
    step("bp_lhu", 1'b1, 1'b0, OP_HU, 12'h052, 32'd0, 32'h0000_1357, 1'b0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_hs.md
# data_mem_hs

Handshaked, parametrised successor of the single-cycle data memory in the RV32 core's MEM stage. Byte-addressed, word-organised storage with RV32 load/store semantics (LB/LH/LW/LBU/LHU, SB/SH/SW). Adds valid/ready request and response channels, configurable wait states, byte-enable writes and a misalignment/illegal-op error response. One request is outstanding at a time; the LSU stalls the pipeline on `req_ready`/`rsp_valid`.

## Interface

Parameters:
- `ADDR_WIDTH`, default 12. Byte-address bits. Capacity is 2**ADDR_WIDTH bytes, stored as 2**(ADDR_WIDTH-2) 32-bit words. Legal range is 3..20.
- `WAIT_STATES`, default 0. Extra access cycles, 0..15.

Ports:
- `clk`, in, 1: clock; all logic on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: block can accept a request. Equals (state==IDLE) && rst_n.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_op`, in, 3: RISC-V funct3 code. Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101. Stores: SB=000, SH=001, SW=010.
- `req_addr`, in, ADDR_WIDTH: byte address.
- `req_wdata`, in, 32: store data, LSB-aligned.
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_rdata`, out, 32: extended load data. 0 for stores and errors.
- `rsp_err`, out, 1: misaligned access or illegal op.

## Operation

- FSM states are IDLE, WAIT and RESP.
- In IDLE, `req_valid` && `req_ready` accepts a request:
  - we, op, addr and wdata are registered.
  - Next state is WAIT if WAIT_STATES>0, else RESP.
- In WAIT, a 4-bit counter starts at 0 and increments. When the counter reaches WAIT_STATES-1, the FSM moves to RESP.
- The memory access happens on the clock edge that enters RESP:
  - Stores write the selected byte lanes.
  - `rsp_rdata` and `rsp_err` are registered.
  - `rsp_valid` rises.
- RESP holds `rsp_valid`, `rsp_rdata` and `rsp_err` stable until `rsp_ready`=1. On that handshake edge the FSM returns to IDLE and `rsp_valid` falls.
- `req_valid` is ignored outside IDLE. The request is captured only on acceptance, so the requester may change the input fields afterwards.
- Byte lanes are selected by addr[1:0]:
  - Byte op: lane addr[1:0].
  - Half op: lanes {addr[1],1} and {addr[1],0}.
  - Word op: all four lanes.
- Store data placement:
  - SB: wdata[7:0] is replicated to the selected lane.
  - SH: wdata[15:0] is placed on the selected half.
  - SW: full word.
  - Unselected lanes are unchanged.
- Load extension:
  - LB and LH sign-extend from bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
  - LW returns the word unchanged.
- Error conditions (`rsp_err`=1):
  - half op with addr[0]≠0;
  - word op with addr[1:0]≠0;
  - load op in {011, 110, 111};
  - store op ≥ 011.
- On error: no memory write, `rsp_rdata`=0, same latency as a good access.
- Storage is not reset. Contents are undefined until written.

## Timing

- Reset values: state=IDLE, counter=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `req_ready`=0 while `rst_n`=0.
- Latency from the accept edge to `rsp_valid`=1 is 1+WAIT_STATES cycles.
- Minimum request spacing is 2+WAIT_STATES cycles (accept, access, response handshake, then IDLE). There is no same-cycle re-accept in RESP.
- Reset asserted mid-operation:
  - The pending request is dropped and no response is issued.
  - A store whose RESP-entry edge has not yet occurred is not performed.
- A store followed by a load to the same address returns the new data, because the write completes at or before the load's access edge.
- `rsp_ready` held at 1 while `rsp_valid`=1 produces a one-cycle response.
- `rsp_ready` asserted while `rsp_valid`=0 is ignored.

## Test plan

- **Reset and idle.** Drive rst_n=0 mid-WAIT with a pending SW, then release and read the word → rsp_valid=0 during reset, req_ready=1 one cycle after release, word unchanged.
- **Word write/read, WAIT_STATES=0.** SW 0xDEADBEEF to 0x010, then LW 0x010 → rsp_valid one cycle after each accept, rdata=0xDEADBEEF, err=0.
- **Byte/half extension.** SW 0x80FF7F01 to 0x020, then:
  - LB 0x023 → 0xFFFFFF80
  - LBU 0x023 → 0x00000080
  - LH 0x022 → 0xFFFF80FF
  - LHU 0x020 → 0x00007F01
- **Partial store.** SB 0xAB to 0x031 and SH 0x1234 to 0x032 over a preloaded 0x00000000 word, then LW 0x030 → 0x1234AB00.
- **Misalignment.** LW 0x041, SH 0x043 and load op 011 → err=1 and rdata=0 for each; a following LW 0x040 shows memory unchanged.
- **Wait states and backpressure.** With WAIT_STATES=3 and rsp_ready=0 for 5 cycles:
  - rsp_valid rises 4 cycles after accept;
  - rdata is stable while held;
  - req_ready stays 0 until the cycle after the rsp_ready handshake.
